// File: rtl/core_param_pkg.sv
// rtl/core_param_pkg.sv - shared types and constants for the parametrised accumulator core
// Purpose: FSM state type, destination-field codes and instruction field
//          positions expressed as functions of the data width DW.
// Ports:   none (package).
package core_param_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [1:0] DST_A   = 2'd0;
   localparam logic [1:0] DST_B   = 2'd1;
   localparam logic [1:0] DST_O   = 2'd2;
   localparam logic [1:0] DST_NOP = 2'd3;

   // Instruction layout, MSB first: J C D[1:0] Sreg S imm[DW-1:0]
   function automatic int iw_of(input int dw);
      return dw + 6;
   endfunction

   function automatic int j_pos(input int dw);
      return dw + 5;
   endfunction

   function automatic int c_pos(input int dw);
      return dw + 4;
   endfunction

   function automatic int d_hi(input int dw);
      return dw + 3;
   endfunction

   function automatic int d_lo(input int dw);
      return dw + 2;
   endfunction

   function automatic int sreg_pos(input int dw);
      return dw + 1;
   endfunction

   function automatic int s_pos(input int dw);
      return dw;
   endfunction

endpackage

// File: rtl/core_param_alu.sv
// rtl/core_param_alu.sv - combinational add/subtract unit with carry/borrow
// Purpose: out = a + b (sub=0) or a - b (sub=1); carry is the add carry-out
//          or the subtract borrow (a < b).
//          Build macro CORE_SAT_EN: saturate instead of wrapping (add overflow
//          gives all-ones, subtract underflow gives zero); carry is unchanged.
// Ports:   a, b   in  DW  operands
//          sub    in  1   0 = add, 1 = subtract
//          out    out DW  result
//          carry  out 1   carry (add) or borrow (subtract)
module core_param_alu
   import core_param_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sub,
   output logic [DW-1:0] out,
   output logic          carry
);

   logic [DW:0]   sum;
   logic [DW-1:0] diff;
   logic          borrow;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = a - b;
      borrow = (a < b);
      carry  = sub ? borrow : sum[DW];
`ifdef CORE_SAT_EN
      if (sub) begin
         out = borrow ? '0 : diff;
      end else begin
         out = sum[DW] ? '1 : sum[DW-1:0];
      end
`else
      out = sub ? diff : sum[DW-1:0];
`endif
   end

endmodule

// File: rtl/core_param.sv
// rtl/core_param.sv - parametrised accumulator core with fetch/execute FSM
// Purpose: two-cycle fetch/execute core with registers A, B, O, a carry flag,
//          conditional/unconditional jumps, HALT and a run enable.
//          Build macro CORE_SAT_EN selects saturating arithmetic in the ALU.
// Ports:   clk        in  1   core clock
//          reset      in  1   asynchronous, active-high reset
//          en         in  1   run enable; low stalls every state element
//          imem_addr  out AW  fetch address (= pc)
//          imem_data  in  IW  instruction, combinational from imem_addr
//          out_data   out DW  register O
//          out_valid  out 1   pulse in the cycle after O is written
//          halted     out 1   core stopped by HALT
//          carry      out 1   registered carry/borrow flag
module core_param
   import core_param_pkg::*;
#(
   parameter  int DW = 4,
   parameter  int AW = 4,
   localparam int IW = iw_of(DW)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          halted,
   output logic          carry
);

   localparam int JP = j_pos(DW);
   localparam int CP = c_pos(DW);
   localparam int DH = d_hi(DW);
   localparam int DL = d_lo(DW);
   localparam int RP = sreg_pos(DW);
   localparam int SP = s_pos(DW);

   state_t        state, state_next;
   logic [AW-1:0] pc, pc_next;
   logic [IW-1:0] ir;
   logic [DW-1:0] reg_a, reg_b, reg_o;
   logic          carry_q, valid_q;

   logic          f_j, f_c, f_sreg, f_s;
   logic [1:0]    f_d;
   logic [DW-1:0] f_imm;
   logic [DW-1:0] alu_out, reg_in;
   logic          alu_carry;
   logic          load_ir, wr_a, wr_b, wr_o, wr_carry;

   assign f_j    = ir[JP];
   assign f_c    = ir[CP];
   assign f_d    = ir[DH:DL];
   assign f_sreg = ir[RP];
   assign f_s    = ir[SP];
   assign f_imm  = ir[DW-1:0];

   core_param_alu #(.DW(DW)) u_alu (
      .a     (reg_a),
      .b     (reg_b),
      .sub   (f_s),
      .out   (alu_out),
      .carry (alu_carry)
   );

   assign reg_in = f_sreg ? alu_out : f_imm;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else if (en) begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         FETCH:   state_next = EXEC;
         EXEC:    state_next = (f_j && f_c) ? HALT : FETCH;
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   // Output/control logic; HALT (J=1,C=1) suppresses every write in EXEC
   always_comb begin
      load_ir  = 1'b0;
      wr_a     = 1'b0;
      wr_b     = 1'b0;
      wr_o     = 1'b0;
      wr_carry = 1'b0;
      pc_next  = pc;
      case (state)
         FETCH: load_ir = 1'b1;
         EXEC: begin
            if (!(f_j && f_c)) begin
               wr_carry = 1'b1;
               wr_a     = (f_d == DST_A);
               wr_b     = (f_d == DST_B);
               wr_o     = (f_d == DST_O);
               // Conditional jump tests the carry held before this EXEC
               if (f_j || (f_c && carry_q)) begin
                  pc_next = f_imm[AW-1:0];
               end else begin
                  pc_next = pc + AW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= '0;
         ir      <= '0;
         reg_a   <= '0;
         reg_b   <= '0;
         reg_o   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else if (en) begin
         pc      <= pc_next;
         valid_q <= wr_o;
         if (load_ir)  ir      <= imem_data;
         if (wr_a)     reg_a   <= reg_in;
         if (wr_b)     reg_b   <= reg_in;
         if (wr_o)     reg_o   <= reg_a;
         if (wr_carry) carry_q <= alu_carry;
      end
   end

   assign imem_addr = pc;
   assign out_data  = reg_o;
   assign out_valid = valid_q;
   assign halted    = (state == HALT);
   assign carry     = carry_q;

endmodule

// File: tb/tb_core_param.sv
// tb/tb_core_param.sv - self-checking bench for core_param against an instruction-level model
module tb_core_param;

   logic       clk;
   logic       reset;
   logic       en;
   logic [3:0] imem_addr;
   logic [9:0] imem_data;
   logic [3:0] out_data;
   logic       out_valid;
   logic       halted;
   logic       carry;

   logic [9:0] imem [0:15];
   assign imem_data = imem[imem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   // Instruction-level reference state
   int m_a, m_b, m_o, m_pc;
   int m_cy, m_ov, m_h;

   core_param #(.DW(4), .AW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .carry     (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input int pc, input int o, input int ov,
                            input int cy, input int h);
      check({tag, "_pc"},    32'(imem_addr), 32'(pc));
      check({tag, "_out"},   32'(out_data),  32'(o));
      check({tag, "_valid"}, 32'(out_valid), 32'(ov));
      check({tag, "_carry"}, 32'(carry),     32'(cy));
      check({tag, "_halt"},  32'(halted),    32'(h));
   endtask

   function automatic logic [9:0] ins(input logic j, input logic c, input logic [1:0] d,
                                      input logic sr, input logic s, input logic [3:0] imm);
      return {j, c, d, sr, s, imm};
   endfunction

   function automatic logic [9:0] i_lda(input logic [3:0] v); return ins(0, 0, 2'd0, 0, 0, v); endfunction
   function automatic logic [9:0] i_ldb(input logic [3:0] v); return ins(0, 0, 2'd1, 0, 0, v); endfunction
   function automatic logic [9:0] i_jmp(input logic [3:0] v); return ins(1, 0, 2'd3, 0, 0, v); endfunction
   function automatic logic [9:0] i_jc(input logic [3:0] v);  return ins(0, 1, 2'd3, 0, 0, v); endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 16; i++) imem[i] = ins(0, 0, 2'd3, 0, 0, 4'd0);
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_o = 0; m_pc = 0; m_cy = 0; m_ov = 0; m_h = 0;
   endtask

   // Executes one instruction from the rules: A op B on old values, then writes
   task automatic model_step();
      logic [9:0] w;
      int j, c, d, sr, s, imm, r, cy, rin;
      w   = imem[m_pc];
      j   = int'(w[9]);
      c   = int'(w[8]);
      d   = int'(w[7:6]);
      sr  = int'(w[5]);
      s   = int'(w[4]);
      imm = int'(w[3:0]);
      if (j == 1 && c == 1) begin
         m_h  = 1;
         m_ov = 0;
         return;
      end
      if (s == 1) begin
         cy = (m_a < m_b) ? 1 : 0;
         r  = (m_a - m_b + 16) % 16;
`ifdef CORE_SAT_EN
         if (cy == 1) r = 0;
`endif
      end else begin
         r  = m_a + m_b;
         cy = (r > 15) ? 1 : 0;
`ifdef CORE_SAT_EN
         if (r > 15) r = 15;
`else
         r = r % 16;
`endif
      end
      rin  = (sr == 1) ? r : imm;
      m_ov = 0;
      case (d)
         0: m_a = rin;
         1: m_b = rin;
         2: begin m_o = m_a; m_ov = 1; end
         default: ;
      endcase
      if (j == 1 || (c == 1 && m_cy == 1)) m_pc = imm;
      else m_pc = (m_pc + 1) % 16;
      m_cy = cy;
   endtask

   task automatic stall(input int n, input string tag, input int pc, input int o,
                        input int ov, input int cy, input int h);
      en = 1'b0;
      repeat (n) begin
         tick();
         check_all(tag, pc, o, ov, cy, h);
      end
      en = 1'b1;
   endtask

   // mode 0: no stalls, 1: random stalls, 2: 5-cycle stalls at both points
   task automatic run_instr(input int mode);
      int o_pc, o_o, o_cy, o_ov;
      if (m_h == 1) begin
         tick();
         check_all("halt_hold", m_pc, m_o, 0, m_cy, 1);
         return;
      end
      o_pc = m_pc; o_o = m_o; o_cy = m_cy; o_ov = m_ov;
      if (mode == 2) stall(5, "stall_valid", o_pc, o_o, o_ov, o_cy, 0);
      else if (mode == 1 && $urandom_range(0, 3) == 0)
         stall(int'($urandom_range(1, 4)), "stall_bnd", o_pc, o_o, o_ov, o_cy, 0);
      model_step();
      tick();
      check_all("fetch", o_pc, o_o, 0, o_cy, 0);
      if (mode == 2) stall(5, "stall_exec", o_pc, o_o, 0, o_cy, 0);
      else if (mode == 1 && $urandom_range(0, 3) == 0)
         stall(int'($urandom_range(1, 4)), "stall_exec", o_pc, o_o, 0, o_cy, 0);
      tick();
      check_all("exec", m_pc, m_o, m_ov, m_cy, m_h);
   endtask

   task automatic run_n(input int n, input int mode);
      repeat (n) run_instr(mode);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #2;
      check_all(tag, 0, 0, 0, 0, 0);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic load_prog1();
      fill_nop();
      imem[0] = i_lda(4'd5);
      imem[1] = i_ldb(4'd3);
      imem[2] = ins(0, 0, 2'd0, 1, 0, 4'd0);
      imem[3] = ins(0, 0, 2'd2, 0, 0, 4'd0);
   endtask

   initial begin
      en    = 1'b1;
      reset = 1'b1;
      fill_nop();
      model_reset();
      #2;
      check_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Load, add, output
      load_prog1();
      run_n(4, 0);
      check("t1_out", 32'(out_data), 32'd8);
      check("t1_pc", 32'(imem_addr), 32'd4);
      check("t1_carry", 32'(carry), 32'd0);
      run_n(1, 0);
      check("t1_valid_drop", 32'(out_valid), 32'd0);

      // Same program with stalls in EXEC and in the out_valid cycle
      do_reset("rst_t1s");
      run_n(5, 2);
      check("t1s_out", 32'(out_data), 32'd8);
      check("t1s_pc", 32'(imem_addr), 32'd5);

      // Carry-conditional jump taken, then not taken
      do_reset("rst_t2");
      fill_nop();
      imem[0]  = i_lda(4'd12);
      imem[1]  = i_ldb(4'd7);
      imem[2]  = ins(0, 0, 2'd0, 1, 0, 4'd0);
      imem[3]  = i_jc(4'd6);
      imem[6]  = ins(0, 0, 2'd2, 0, 0, 4'd0);
      imem[7]  = i_lda(4'd1);
      imem[8]  = i_ldb(4'd2);
      imem[9]  = ins(0, 0, 2'd0, 1, 0, 4'd0);
      imem[10] = i_jc(4'd0);
      run_n(3, 0);
      check("t2_carry", 32'(carry), 32'd1);
      run_n(1, 0);
      check("t2_jump", 32'(imem_addr), 32'd6);
      run_n(1, 0);
      check("t2_a", 32'(out_data), 32'd3);
      run_n(4, 0);
      check("t2_nojump", 32'(imem_addr), 32'd11);

      // Subtract with borrow
      do_reset("rst_t3");
      fill_nop();
      imem[0] = i_lda(4'd2);
      imem[1] = i_ldb(4'd5);
      imem[2] = ins(0, 0, 2'd0, 1, 1, 4'd0);
      imem[3] = ins(0, 0, 2'd2, 0, 1, 4'd0);
      run_n(3, 0);
      check("t3_borrow", 32'(carry), 32'd1);
      run_n(1, 0);
`ifdef CORE_SAT_EN
      check("t3_sub", 32'(out_data), 32'd0);
`else
      check("t3_sub", 32'(out_data), 32'd13);
`endif

      // Straight-line wrap past pc=15, then JMP 0 at pc=15
      do_reset("rst_t4");
      fill_nop();
      run_n(17, 0);
      check("t4_wrap", 32'(imem_addr), 32'd1);
      imem[15] = i_jmp(4'd0);
      run_n(15, 0);
      check("t4_jmp", 32'(imem_addr), 32'd0);

      // HALT at pc=3, sticky, then reset restarts
      do_reset("rst_t5");
      fill_nop();
      imem[0] = i_lda(4'd9);
      imem[1] = ins(0, 0, 2'd2, 0, 0, 4'd0);
      imem[2] = i_ldb(4'd4);
      imem[3] = ins(1, 1, 2'd0, 1, 0, 4'd0);
      run_n(4, 0);
      check("t5_halted", 32'(halted), 32'd1);
      check("t5_pc", 32'(imem_addr), 32'd3);
      run_n(20, 0);
      check("t5_hold_out", 32'(out_data), 32'd9);
      do_reset("rst_t5b");
      run_n(1, 0);
      check("t5_restart", 32'(imem_addr), 32'd1);

      // Reset during EXEC aborts the pending write
      do_reset("rst_t6");
      fill_nop();
      imem[0] = i_lda(4'd7);
      imem[1] = ins(0, 0, 2'd2, 0, 0, 4'd0);
      imem[2] = i_lda(4'd3);
      imem[3] = ins(0, 0, 2'd2, 0, 0, 4'd0);
      run_n(2, 0);
      check("t6_out", 32'(out_data), 32'd7);
      tick();
      do_reset("rst_exec");
      imem[0] = ins(0, 0, 2'd2, 0, 0, 4'd0);
      run_n(1, 0);
      check("t6_abort", 32'(out_data), 32'd0);

      // Random programs with random stalls
      for (int t = 0; t < 8; t++) begin
         do_reset("rst_rand");
         for (int i = 0; i < 16; i++) begin
            imem[i] = 10'($urandom);
            if (imem[i][9] && imem[i][8] && $urandom_range(0, 5) != 0) imem[i][8] = 1'b0;
         end
         run_n(40, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
